// File: rtl/operand_entry.sv
// Keypad front end: accumulates decimal key codes into a signed operand
// and strobes it into the downstream operand register on ENTER.
module operand_entry #(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_ready,
  output logic             load,
  output logic [WIDTH-1:0] data_out,
  output logic [3:0]       digit_count,
  output logic             negative,
  output logic             overflow
);

  localparam int XW = WIDTH + 4;
  localparam logic [XW-1:0] LIMIT =
    (XW'(1) << (WIDTH - 1)) - XW'(1);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       key_q;
  logic [WIDTH-2:0] mag;
  logic [XW-1:0]    ext;
  logic [XW-1:0]    prod;
  logic [WIDTH-1:0] sgn;
  logic             is_digit;
  logic             lead_zero;
  logic             fits;

  always_comb begin
    state_nxt = state;
    key_ready = 1'b0;
    unique case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) state_nxt = EXEC;
      end
      EXEC: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // m*10+d at WIDTH+4 bits so the range test cannot wrap
  assign ext       = XW'(mag);
  assign prod      = (ext << 3) + (ext << 1) + XW'(key_q);
  assign is_digit  = key_q <= 4'd9;
  assign lead_zero = (mag == '0) && (key_q == 4'd0);
  assign fits      = (prod <= LIMIT) &&
                     (digit_count < 4'(MAX_DIGITS));
  assign sgn       = {1'b0, mag};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      key_q       <= '0;
      mag         <= '0;
      data_out    <= '0;
      load        <= 1'b0;
      digit_count <= '0;
      negative    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state <= state_nxt;
      load  <= 1'b0;
      if (state == IDLE && key_valid) key_q <= key_code;
      if (state == EXEC) begin
        unique case (1'b1)
          is_digit: begin
            if (lead_zero) begin
              mag <= mag;
            end else if (fits) begin
              mag         <= prod[WIDTH-2:0];
              digit_count <= digit_count + 4'd1;
            end else begin
              overflow <= 1'b1;
            end
          end
          key_q == 4'hA: begin
            data_out    <= negative ? (WIDTH'(0) - sgn) : sgn;
            load        <= 1'b1;
            mag         <= '0;
            digit_count <= '0;
            negative    <= 1'b0;
            overflow    <= 1'b0;
          end
          key_q == 4'hB: begin
            mag         <= '0;
            digit_count <= '0;
            negative    <= 1'b0;
            overflow    <= 1'b0;
          end
          key_q == 4'hC: negative <= ~negative;
          default: mag <= mag;
        endcase
      end
    end
  end

endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
Keypad-to-operand front end of the calculator datapath. It accepts key codes over a valid/ready handshake and accumulates decimal digits into a signed two's-complement value. On ENTER it presents the value on data_out with a one-cycle load strobe, directly driving the load/data_in inputs of the downstream 32-bit operand register.

Parameters:
WIDTH, 32, operand width in bits (two's complement)
MAX_DIGITS, 10, maximum significant decimal digits accepted per entry

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
key_valid  input  1  key_code is valid this cycle
key_code  input  4  0-9 digit, 4'hA ENTER, 4'hB CLEAR, 4'hC NEGATE, 4'hD-4'hF ignored
key_ready  output  1  block can accept a key this cycle
load  output  1  one-cycle strobe; data_out holds a new operand
data_out  output  WIDTH  last entered operand, two's complement
digit_count  output  4  significant digits in the current entry
negative  output  1  sign of the current entry
overflow  output  1  sticky: a digit was rejected in the current entry

Behaviour:
- Reset (async, immediate): state=IDLE, accumulator=0, data_out=0, load=0, digit_count=0, negative=0, overflow=0, key_ready=1. A key latched in EXEC is discarded.
- Two-state FSM.
  - IDLE: key_ready=1. On a rising edge with key_valid&&key_ready, latch key_code and go to EXEC.
  - EXEC: key_ready=0. Apply the latched key at the end of the cycle, then return to IDLE unconditionally. Throughput is 1 key per 2 cycles.
- key_valid while key_ready=0: not accepted. The source holds key_valid and key_code until it sees key_ready=1.
- Digit d, accumulator magnitude m (unsigned, WIDTH-1 bits):
  - m==0 and d==0: no change; digit_count stays 0 (leading zero).
  - digit_count==MAX_DIGITS, or m*10+d > 2^(WIDTH-1)-1: digit rejected, m unchanged, overflow<=1.
  - Otherwise m<=m*10+d and digit_count<=digit_count+1. Compute m*10 as (m<<3)+(m<<1) at WIDTH+4 bits so the comparison cannot wrap.
- NEGATE: negative<=~negative. No effect on m or digit_count.
- CLEAR: m, digit_count, negative and overflow all <=0. data_out is unchanged.
- ENTER:
  - data_out <= negative ? -m : m (two's complement, WIDTH bits).
  - load=1 for exactly the one cycle following EXEC, the same cycle data_out first shows the new value.
  - m, digit_count, negative and overflow <=0.
  - ENTER with no digits gives data_out=0 and a load pulse. Negative zero is emitted as 0.
- Ignored codes 4'hD-4'hF: accepted through the handshake, no state change, no load.
- data_out holds its value between ENTERs. load is 0 in every other cycle.
- Range is symmetric: ±(2^(WIDTH-1)-1). -2^(WIDTH-1) is not enterable.
- Outputs are registered; there is no combinational path from key inputs to outputs. key_ready is a decode of the FSM state.

Test Plan:
- Reset, then keys 1,2,3,ENTER with key_valid held high → key_ready toggles 1/0 each cycle; digit_count goes 1,2,3,0; load high exactly one cycle; data_out=32'd123.
- Keys 4,2,NEGATE,ENTER → data_out=32'hFFFFFFD6 (-42), load pulse; negative returns to 0 after ENTER.
- Keys 2,1,4,7,4,8,3,6,4,7 (2147483647), then 9 → the 9 is rejected, overflow=1, digit_count=10; ENTER → data_out=32'h7FFFFFFF, overflow cleared.
- Keys 0,0,5, CLEAR, 7, ENTER → digit_count 0,0,1,0,1; data_out=7; data_out unchanged at CLEAR.
- Key 9 accepted, reset asserted mid-EXEC → all outputs return to their reset values immediately; after release, ENTER gives data_out=0 with one load pulse.
- Key 4'hE, then ENTER with no digits → no load after 4'hE; ENTER produces a load with data_out=0.
